// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - Shared Wishbone arbiter state type, width defaults and round-robin helper
package wb_pkg;

    localparam int WB_ADR_WIDTH   = 32;
    localparam int WB_DAT_WIDTH   = 32;
    localparam int WB_MAX_MASTERS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } wb_arb_state_t;

    // First requester strictly after last, wrapping modulo n; returns last when nobody requests.
    function automatic int unsigned wb_rr_next(
        input logic [WB_MAX_MASTERS-1:0] req,
        input int unsigned               last,
        input int unsigned               n
    );
        int unsigned c;
        logic        found;
        wb_rr_next = last;
        found      = 1'b0;
        for (int unsigned k = 1; k <= WB_MAX_MASTERS; k++) begin
            c = (last + k) % n;
            if (!found && (k <= n) && (|(req & (32'd1 << c)))) begin
                wb_rr_next = c;
                found      = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// rtl/wb_rr_picker.sv - Combinational round-robin priority encoder over the master cyc lines
module wb_rr_picker
    import wb_pkg::*;
#(
    parameter  int m_count = 2,
    localparam int IW      = $clog2(m_count)
) (
    input  logic [m_count-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [IW-1:0]      winner,
    output logic               any
);

    logic [WB_MAX_MASTERS-1:0] w_req_ext;

    always_comb begin
        w_req_ext                = '0;
        w_req_ext[m_count-1:0]   = req;
    end

    assign winner = IW'(wb_rr_next(w_req_ext, 32'(last), m_count));
    assign any    = |req;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - Round-robin Wishbone arbiter holding the grant for the owner's whole cyc envelope
// Define WB_ARBITER_TIMEOUT_EN to compile in the ack-timeout counter and the ABORT state.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter  int m_count        = 2,
    parameter  int adr_width      = WB_ADR_WIDTH,
    parameter  int dat_width      = WB_DAT_WIDTH,
    parameter  int sel_width      = dat_width / 8,
    parameter  int timeout_cycles = 255,
    localparam int GW             = $clog2(m_count)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [m_count-1:0]             m_cyc,
    input  logic [m_count-1:0]             m_stb,
    input  logic [m_count-1:0]             m_we,
    input  logic [m_count*adr_width-1:0]   m_adr,
    input  logic [m_count*dat_width-1:0]   m_datwr,
    input  logic [m_count*sel_width-1:0]   m_sel,
    output logic [m_count-1:0]             m_ack,
    output logic [m_count-1:0]             m_err,
    output logic [dat_width-1:0]           m_datrd,
    output logic                           s_cyc,
    output logic                           s_stb,
    output logic                           s_we,
    output logic [adr_width-1:0]           s_adr,
    output logic [dat_width-1:0]           s_datwr,
    output logic [sel_width-1:0]           s_sel,
    input  logic                           s_ack,
    input  logic [dat_width-1:0]           s_datrd,
    output logic [GW-1:0]                  grant,
    output logic                           grant_valid
);

    wb_arb_state_t r_state;
    wb_arb_state_t w_state_next;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_last;
    logic [GW-1:0] w_winner;
    logic          w_any;
    logic          w_own_cyc;
    logic          w_timeout;

    if (m_count < 2 || timeout_cycles < 1) begin : g_bad_cfg
        $error("wb_arbiter: m_count must be >= 2 and timeout_cycles >= 1");
    end

    wb_rr_picker #(
        .m_count (m_count)
    ) u_picker (
        .req     (m_cyc),
        .last    (r_last),
        .winner  (w_winner),
        .any     (w_any)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= GW'(m_count - 1);
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_any) begin
                r_grant <= w_winner;
                r_last  <= w_winner;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_next = BUSY;
            BUSY: begin
                if (!w_own_cyc)     w_state_next = IDLE;
                else if (w_timeout) w_state_next = ABORT;
            end
            default: w_state_next = IDLE;
        endcase
    end

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(timeout_cycles + 1);

    logic [CW-1:0] r_tmo_cnt;

    // Counts only stalled strobes; any ack or leaving BUSY restarts the window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state != BUSY || s_ack) begin
            r_tmo_cnt <= '0;
        end else if (s_stb) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = s_stb && !s_ack && (r_tmo_cnt == CW'(timeout_cycles - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_datwr = '0;
        s_sel   = '0;
        m_ack   = '0;
        m_err   = '0;
        for (int i = 0; i < m_count; i++) begin
            if (r_grant == GW'(i)) begin
                if (r_state == BUSY) begin
                    s_cyc    = m_cyc[i];
                    s_stb    = m_stb[i];
                    s_we     = m_we[i];
                    s_adr    = m_adr[i*adr_width +: adr_width];
                    s_datwr  = m_datwr[i*dat_width +: dat_width];
                    s_sel    = m_sel[i*sel_width +: sel_width];
                    // An ack landing as the owner releases cyc belongs to no transfer.
                    m_ack[i] = s_ack && m_cyc[i];
                end
`ifdef WB_ARBITER_TIMEOUT_EN
                if (r_state == ABORT) begin
                    m_err[i] = 1'b1;
                end
`endif
            end
        end
    end

    assign w_own_cyc   = m_cyc[r_grant];
    assign grant       = r_grant;
    assign grant_valid = (r_state == BUSY);
    assign m_datrd     = s_datrd;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - Directed and randomized self-checking bench for wb_arbiter
module tb_wb_arbiter;

    localparam int M  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;
    localparam int GW = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [M-1:0]    m_cyc, m_stb, m_we;
    logic [M*AW-1:0] m_adr;
    logic [M*DW-1:0] m_datwr;
    logic [M*SW-1:0] m_sel;
    logic [M-1:0]    m_ack, m_err;
    logic [DW-1:0]   m_datrd;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_datwr;
    logic [SW-1:0]   s_sel;
    logic            s_ack;
    logic [DW-1:0]   s_datrd;
    logic [GW-1:0]   grant;
    logic            grant_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: current owner (-1 = none), last winner, abort flag, stall counter.
    int mdl_owner = -1;
    int mdl_last  = M - 1;
    bit mdl_abort = 1'b0;
    int mdl_cnt   = 0;

    wb_arbiter #(
        .m_count        (M),
        .adr_width      (AW),
        .dat_width      (DW),
        .sel_width      (SW),
        .timeout_cycles (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .m_cyc       (m_cyc),
        .m_stb       (m_stb),
        .m_we        (m_we),
        .m_adr       (m_adr),
        .m_datwr     (m_datwr),
        .m_sel       (m_sel),
        .m_ack       (m_ack),
        .m_err       (m_err),
        .m_datrd     (m_datrd),
        .s_cyc       (s_cyc),
        .s_stb       (s_stb),
        .s_we        (s_we),
        .s_adr       (s_adr),
        .s_datwr     (s_datwr),
        .s_sel       (s_sel),
        .s_ack       (s_ack),
        .s_datrd     (s_datrd),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mdl_owner = -1;
            mdl_last  = M - 1;
            mdl_abort = 1'b0;
            mdl_cnt   = 0;
        end else if (mdl_abort) begin
            mdl_abort = 1'b0;
            mdl_owner = -1;
        end else if (mdl_owner < 0) begin
            for (int k = 1; k <= M; k++) begin
                if (mdl_owner < 0 && m_cyc[(mdl_last + k) % M]) begin
                    mdl_owner = (mdl_last + k) % M;
                end
            end
            if (mdl_owner >= 0) mdl_last = mdl_owner;
            mdl_cnt = 0;
        end else if (!m_cyc[mdl_owner]) begin
            mdl_owner = -1;
        end else begin
`ifdef WB_ARBITER_TIMEOUT_EN
            if (s_ack) begin
                mdl_cnt = 0;
            end else if (m_stb[mdl_owner]) begin
                mdl_cnt = mdl_cnt + 1;
                if (mdl_cnt == TO) mdl_abort = 1'b1;
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_adr = '0; m_datwr = '0; m_sel = '0;
        s_ack = 1'b0; s_datrd = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clock);
        n_tests++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", grant_valid); end
        n_tests++; if (grant !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", grant); end
        n_tests++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin n_fail++; $display("FAIL reset_s_ctl: got %b want 000", {s_cyc, s_stb, s_we}); end
        n_tests++; if ({s_adr, s_datwr, s_sel} !== '0) begin n_fail++; $display("FAIL reset_s_fields: got %h want 0", {s_adr, s_datwr, s_sel}); end
        n_tests++; if ({m_ack, m_err} !== 6'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b want 000000", {m_ack, m_err}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_master();
        int ack_seen;
        ack_seen = 0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_adr[31:0] = 32'h0000_0100; m_datwr[31:0] = 32'hDEAD_BEEF; m_sel[3:0] = 4'hF;
        @(negedge clock);
        n_tests++; if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL single_latency: got s_cyc=%0b want 0", s_cyc); end
        for (int c = 1; c <= 4; c++) begin
            tick();
            s_ack = (c == 3);
            @(negedge clock);
            n_tests++; if ({grant_valid, grant, s_cyc, s_stb, s_we} !== 6'b1_00_111) begin n_fail++; $display("FAIL single_ctl[%0d]: got %b want 100111", c, {grant_valid, grant, s_cyc, s_stb, s_we}); end
            n_tests++; if ({s_adr, s_datwr, s_sel} !== {32'h100, 32'hDEADBEEF, 4'hF}) begin n_fail++; $display("FAIL single_fields[%0d]: got %h want %h", c, {s_adr, s_datwr, s_sel}, {32'h100, 32'hDEADBEEF, 4'hF}); end
            n_tests++; if (m_ack !== ((c == 3) ? 3'b001 : 3'b000)) begin n_fail++; $display("FAIL single_ack[%0d]: got %b want %b", c, m_ack, (c == 3) ? 3'b001 : 3'b000); end
            if (m_ack[0]) ack_seen++;
        end
        n_tests++; if (ack_seen != 1) begin n_fail++; $display("FAIL single_ack_count: got %0d want 1", ack_seen); end
        tick();
        clear_inputs();
        tick();
        @(negedge clock);
        n_tests++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL single_release: got %0b want 0", grant_valid); end
        tick();
    endtask

    task automatic test_contention();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
        m_cyc = 3'b011; m_stb = 3'b011;
        tick();
        @(negedge clock);
        n_tests++; if ({grant_valid, grant} !== 3'b1_00) begin n_fail++; $display("FAIL cont_first: got %b want 100", {grant_valid, grant}); end
        tick(); tick();
        m_cyc = 3'b010;
        @(negedge clock);
        n_tests++; if ({grant_valid, s_cyc} !== 2'b10) begin n_fail++; $display("FAIL cont_drop: got %b want 10", {grant_valid, s_cyc}); end
        tick();
        @(negedge clock);
        n_tests++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL cont_dead: got %0b want 0", grant_valid); end
        tick();
        @(negedge clock);
        n_tests++; if ({grant_valid, grant, s_cyc} !== 4'b1_01_1) begin n_fail++; $display("FAIL cont_second: got %b want 1011", {grant_valid, grant, s_cyc}); end
        tick();
        m_cyc = 3'b000;
        tick();
        m_cyc = 3'b011;
        tick();
        @(negedge clock);
        n_tests++; if ({grant_valid, grant} !== 3'b1_00) begin n_fail++; $display("FAIL cont_wrap: got %b want 100", {grant_valid, grant}); end
        tick();
        m_cyc = 3'b110; m_stb = 3'b110;
        tick(); tick();
        @(negedge clock);
        n_tests++; if (grant !== 2'd1) begin n_fail++; $display("FAIL cont_ptr1: got %0d want 1", grant); end
        tick();
        m_cyc = 3'b100;
        tick(); tick();
        @(negedge clock);
        n_tests++; if ({grant_valid, grant} !== 3'b1_10) begin n_fail++; $display("FAIL cont_ptr2: got %b want 110", {grant_valid, grant}); end
        tick();
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_block_hold();
        int beats;
        beats = 0;
        m_cyc = 3'b010;
        tick();
        m_cyc = 3'b011;
        for (int b = 0; b < 4; b++) begin
            m_stb[1] = 1'b1; s_ack = 1'b1;
            @(negedge clock);
            n_tests++; if ({grant_valid, grant, m_ack} !== 6'b1_01_010) begin n_fail++; $display("FAIL hold_beat[%0d]: got %b want 101010", b, {grant_valid, grant, m_ack}); end
            if (m_ack[1]) beats++;
            tick();
            m_stb[1] = 1'b0; s_ack = 1'b0;
            @(negedge clock);
            n_tests++; if ({grant, m_ack} !== 5'b01_000) begin n_fail++; $display("FAIL hold_gap[%0d]: got %b want 01000", b, {grant, m_ack}); end
            tick();
        end
        n_tests++; if (beats != 4) begin n_fail++; $display("FAIL hold_beats: got %0d want 4", beats); end
        m_cyc = 3'b001;
        tick(); tick();
        @(negedge clock);
        n_tests++; if ({grant_valid, grant} !== 3'b1_00) begin n_fail++; $display("FAIL hold_next: got %b want 100", {grant_valid, grant}); end
        tick();
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_ack_isolation();
        logic [DW-1:0] d;
        d = $urandom;
        s_ack = 1'b1; s_datrd = d;
        @(negedge clock);
        n_tests++; if (m_ack !== 3'b000) begin n_fail++; $display("FAIL iso_idle_ack: got %b want 000", m_ack); end
        n_tests++; if (m_datrd !== d) begin n_fail++; $display("FAIL iso_datrd: got %h want %h", m_datrd, d); end
        tick();
        s_ack = 1'b0;
        m_cyc = 3'b001; m_stb = 3'b001;
        tick(); tick();
        m_cyc = 3'b000; s_ack = 1'b1;
        @(negedge clock);
        n_tests++; if ({m_ack, s_cyc} !== 4'b0000) begin n_fail++; $display("FAIL iso_drop_ack: got %b want 0000", {m_ack, s_cyc}); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        m_cyc = 3'b001; m_stb = 3'b001;
        tick();
        s_ack = 1'b1;
        #1;
        n_tests++; if (m_ack !== 3'b001) begin n_fail++; $display("FAIL rst_pre_ack: got %b want 001", m_ack); end
        reset = 1'b1;
        #1;
        n_tests++; if ({s_cyc, grant_valid, m_ack} !== 5'b0) begin n_fail++; $display("FAIL rst_async: got %b want 00000", {s_cyc, grant_valid, m_ack}); end
        s_ack = 1'b0;
        tick();
        reset = 1'b0;
        m_cyc = 3'b011; m_stb = 3'b011;
        tick();
        @(negedge clock);
        n_tests++; if ({grant_valid, grant} !== 3'b1_00) begin n_fail++; $display("FAIL rst_m0_first: got %b want 100", {grant_valid, grant}); end
        tick();
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_timeout();
        m_cyc = 3'b001; m_stb = 3'b001;
        tick();
        m_cyc = 3'b011;
`ifdef WB_ARBITER_TIMEOUT_EN
        for (int c = 1; c <= TO; c++) begin
            @(negedge clock);
            n_tests++; if ({grant_valid, s_cyc, m_err} !== 5'b11_000) begin n_fail++; $display("FAIL tmo_busy[%0d]: got %b want 11000", c, {grant_valid, s_cyc, m_err}); end
            tick();
        end
        @(negedge clock);
        n_tests++; if ({m_err, m_ack, s_cyc, grant_valid} !== 8'b001_000_0_0) begin n_fail++; $display("FAIL tmo_abort: got %b want 00100000", {m_err, m_ack, s_cyc, grant_valid}); end
        tick();
        @(negedge clock);
        n_tests++; if ({grant_valid, m_err} !== 4'b0) begin n_fail++; $display("FAIL tmo_idle: got %b want 0000", {grant_valid, m_err}); end
        tick();
        @(negedge clock);
        n_tests++; if ({grant_valid, grant} !== 3'b1_01) begin n_fail++; $display("FAIL tmo_next: got %b want 101", {grant_valid, grant}); end
`else
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            n_tests++; if ({grant_valid, grant, s_cyc, m_err} !== 7'b1_00_1_000) begin n_fail++; $display("FAIL hung_hold[%0d]: got %b want 1001000", c, {grant_valid, grant, s_cyc, m_err}); end
            tick();
        end
`endif
        clear_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_random();
        int            o;
        logic          e_valid, e_cyc, e_stb, e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        logic [M-1:0]  e_ack, e_err;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < M; i++) begin
                if (m_cyc[i]) m_cyc[i] = ($urandom_range(0, 4) != 0);
                else          m_cyc[i] = ($urandom_range(0, 2) == 0);
            end
            m_stb   = M'($urandom);
            m_we    = M'($urandom);
            m_adr   = {$urandom, $urandom, $urandom};
            m_datwr = {$urandom, $urandom, $urandom};
            m_sel   = (M*SW)'($urandom);
            s_ack   = ($urandom_range(0, 3) == 0);
            s_datrd = $urandom;
            @(negedge clock);
            o       = mdl_owner;
            e_valid = (o >= 0) && !mdl_abort;
            e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
            e_adr = '0; e_dat = '0; e_sel = '0; e_ack = '0; e_err = '0;
            if (e_valid) begin
                e_cyc = m_cyc[o]; e_stb = m_stb[o]; e_we = m_we[o];
                e_adr = m_adr[o*AW +: AW]; e_dat = m_datwr[o*DW +: DW]; e_sel = m_sel[o*SW +: SW];
                if (s_ack && m_cyc[o]) e_ack = M'(1 << o);
            end
            if (mdl_abort) e_err = M'(1 << o);
            n_tests++; if (grant_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", n, grant_valid, e_valid); end
            n_tests++; if (e_valid && grant !== GW'(o)) begin n_fail++; $display("FAIL rnd_grant[%0d]: got %0d want %0d", n, grant, o); end
            n_tests++; if ({s_cyc, s_stb, s_we} !== {e_cyc, e_stb, e_we}) begin n_fail++; $display("FAIL rnd_s_ctl[%0d]: got %b want %b", n, {s_cyc, s_stb, s_we}, {e_cyc, e_stb, e_we}); end
            n_tests++; if ({s_adr, s_datwr, s_sel} !== {e_adr, e_dat, e_sel}) begin n_fail++; $display("FAIL rnd_s_fields[%0d]: got %h want %h", n, {s_adr, s_datwr, s_sel}, {e_adr, e_dat, e_sel}); end
            n_tests++; if ({m_ack, m_err} !== {e_ack, e_err}) begin n_fail++; $display("FAIL rnd_ack_err[%0d]: got %b want %b", n, {m_ack, m_err}, {e_ack, e_err}); end
            n_tests++; if (m_datrd !== s_datrd) begin n_fail++; $display("FAIL rnd_datrd[%0d]: got %h want %h", n, m_datrd, s_datrd); end
            tick();
        end
        clear_inputs();
        tick(); tick(); tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_master();
        test_contention();
        test_block_hold();
        test_ack_isolation();
        test_reset_mid_transfer();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
